// File: rtl/r16_pkg.sv
// Shared types, widths and the bank-mapping digit sum for the radix-16 NTT
// schedulers and address generator.
package r16_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } r16_sched_state_e;

    localparam int R16_LANES   = 16;
    localparam int R16_BANK_W  = 4;
    localparam int R16_STAGE_W = 2;
    localparam int R16_DRAIN_W = 6;

    // Base-16 digit sum wraps mod 16, which is exactly the bank number.
    function automatic logic [3:0] r16_digit_sum(input logic [15:0] idx);
        r16_digit_sum = idx[3:0] + idx[7:4] + idx[11:8] + idx[15:12];
    endfunction

endpackage

// File: rtl/r16_addr_gen.sv
// Combinational (stage, group) to per-lane bank/in-bank address and twiddle
// base for one radix-16 butterfly issue.
module r16_addr_gen
    import r16_pkg::*;
#(
    parameter int LOG_N = 12
) (
    input  logic [R16_STAGE_W-1:0]            stage,
    input  logic [LOG_N-5:0]                  group,
    output logic [R16_LANES*(LOG_N-4)-1:0]    ma,
    output logic [R16_LANES*R16_BANK_W-1:0]   bn,
    output logic [LOG_N-5:0]                  tw_base
);

    localparam int GW = LOG_N - 4;

    logic [4:0]       sh_s;
    logic [4:0]       tw_sh_s;
    logic [LOG_N-1:0] t_s;
    logic [LOG_N-1:0] g_ext_s;
    logic [LOG_N-1:0] lo_s;
    logic [LOG_N-1:0] hi_s;
    logic [LOG_N-1:0] idx_s;

    // T = 16^s is a power of two, so divide/modulo/multiply by T become shifts and masks.
    always_comb begin
        ma      = {(R16_LANES*GW){1'b0}};
        bn      = {(R16_LANES*R16_BANK_W){1'b0}};
        idx_s   = {LOG_N{1'b0}};
        sh_s    = {1'b0, stage, 2'b00};
        tw_sh_s = 5'(GW) - sh_s;
        t_s     = LOG_N'(1) << sh_s;
        g_ext_s = LOG_N'(group);
        lo_s    = g_ext_s & (t_s - LOG_N'(1));
        hi_s    = (g_ext_s >> sh_s) << (sh_s + 5'd4);
        tw_base = lo_s[GW-1:0] << tw_sh_s;
        for (int j = 0; j < R16_LANES; j++) begin
            idx_s = hi_s + lo_s + (LOG_N'(j) << sh_s);
            ma[j*GW +: GW]                 = idx_s[LOG_N-1:4];
            bn[j*R16_BANK_W +: R16_BANK_W] = r16_digit_sum(16'(idx_s));
        end
    end

endmodule

// File: rtl/r16_ntt_sched.sv
// Stage/group scheduler for the radix-16 NTT datapath: issues conflict-free
// lane addresses per group and drains the butterfly pipeline between stages.
module r16_ntt_sched
    import r16_pkg::*;
#(
    parameter int LOG_N  = 12,
    parameter int BU_LAT = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               stall,
    output logic                               busy,
    output logic                               issue_valid,
    output logic [R16_STAGE_W-1:0]             stage_idx,
    output logic [LOG_N-5:0]                   group_idx,
    output logic [R16_LANES*(LOG_N-4)-1:0]     ma_idx,
    output logic [R16_LANES*R16_BANK_W-1:0]    bn_idx,
    output logic [LOG_N-5:0]                   tw_base,
    output logic                               ntt_done
);

    localparam int GW = LOG_N - 4;
    localparam logic [GW-1:0]             G_LAST     = {GW{1'b1}};
    localparam logic [R16_STAGE_W-1:0]    S_LAST     = R16_STAGE_W'(LOG_N/4 - 1);
    localparam logic [R16_DRAIN_W-1:0]    DRAIN_LOAD = R16_DRAIN_W'(BU_LAT + 1);

    r16_sched_state_e              state_r, state_s;
    logic [R16_STAGE_W-1:0]        stage_r, stage_s;
    logic [GW-1:0]                 group_r, group_s;
    logic [R16_DRAIN_W-1:0]        drain_r, drain_s;
    logic                          issue_s;

    logic [R16_LANES*GW-1:0]          ma_s;
    logic [R16_LANES*R16_BANK_W-1:0]  bn_s;
    logic [GW-1:0]                    tw_s;

    logic                             busy_r;
    logic                             issue_valid_r;
    logic                             ntt_done_r;
    logic [R16_STAGE_W-1:0]           stage_idx_r;
    logic [GW-1:0]                    group_idx_r;
    logic [R16_LANES*GW-1:0]          ma_r;
    logic [R16_LANES*R16_BANK_W-1:0]  bn_r;
    logic [GW-1:0]                    tw_r;

    r16_addr_gen #(.LOG_N(LOG_N)) u_addr_gen (
        .stage   (stage_r),
        .group   (group_r),
        .ma      (ma_s),
        .bn      (bn_s),
        .tw_base (tw_s)
    );

    // Next-state, counter and issue-enable logic.
    always_comb begin
        state_s = state_r;
        stage_s = stage_r;
        group_s = group_r;
        drain_s = drain_r;
        issue_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (!stall) begin
                    issue_s = 1'b1;
                    if (group_r == G_LAST) begin
                        state_s = DRAIN;
                        group_s = {GW{1'b0}};
                        drain_s = DRAIN_LOAD;
                    end else begin
                        group_s = group_r + GW'(1);
                    end
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                // Leaving on the count of 1 gives exactly BU_LAT+1 cycles in DRAIN.
                if (drain_r == R16_DRAIN_W'(1)) begin
                    drain_s = {R16_DRAIN_W{1'b0}};
                    if (stage_r == S_LAST) begin
                        state_s = DONE;
                        stage_s = {R16_STAGE_W{1'b0}};
                    end else begin
                        state_s = RUN;
                        stage_s = stage_r + R16_STAGE_W'(1);
                    end
                end else begin
                    drain_s = drain_r - R16_DRAIN_W'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
                stage_s = {R16_STAGE_W{1'b0}};
                group_s = {GW{1'b0}};
                drain_s = {R16_DRAIN_W{1'b0}};
            end
            default: begin
                state_s = IDLE;
                stage_s = {R16_STAGE_W{1'b0}};
                group_s = {GW{1'b0}};
                drain_s = {R16_DRAIN_W{1'b0}};
            end
        endcase
    end

    // FSM state and stage/group/drain counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            stage_r <= {R16_STAGE_W{1'b0}};
            group_r <= {GW{1'b0}};
            drain_r <= {R16_DRAIN_W{1'b0}};
        end else begin
            state_r <= state_s;
            stage_r <= stage_s;
            group_r <= group_s;
            drain_r <= drain_s;
        end
    end

    // Registered outputs; issue fields hold their last value when not issuing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r        <= 1'b0;
            issue_valid_r <= 1'b0;
            ntt_done_r    <= 1'b0;
            stage_idx_r   <= {R16_STAGE_W{1'b0}};
            group_idx_r   <= {GW{1'b0}};
            ma_r          <= {(R16_LANES*GW){1'b0}};
            bn_r          <= {(R16_LANES*R16_BANK_W){1'b0}};
            tw_r          <= {GW{1'b0}};
        end else begin
            busy_r        <= (state_r != IDLE) || (state_s != IDLE);
            ntt_done_r    <= (state_r == DONE);
            issue_valid_r <= issue_s;
            if (issue_s) begin
                stage_idx_r <= stage_r;
                group_idx_r <= group_r;
                ma_r        <= ma_s;
                bn_r        <= bn_s;
                tw_r        <= tw_s;
            end else begin
                stage_idx_r <= stage_idx_r;
                group_idx_r <= group_idx_r;
                ma_r        <= ma_r;
                bn_r        <= bn_r;
                tw_r        <= tw_r;
            end
        end
    end

    assign busy        = busy_r;
    assign issue_valid = issue_valid_r;
    assign ntt_done    = ntt_done_r;
    assign stage_idx   = stage_idx_r;
    assign group_idx   = group_idx_r;
    assign ma_idx      = ma_r;
    assign bn_idx      = bn_r;
    assign tw_base     = tw_r;

endmodule

// File: tb/tb_r16_ntt_sched.sv
// Randomized self-checking bench for r16_ntt_sched against a formula-level
// issue/drain timeline model and a bank/coverage scoreboard.
module tb_r16_ntt_sched;

    localparam int LOG_N  = 12;
    localparam int BU_LAT = 8;
    localparam int GW     = LOG_N - 4;
    localparam int S      = LOG_N / 4;
    localparam int G      = 1 << GW;
    localparam int NL     = 16;
    localparam int NIDX   = 1 << LOG_N;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 stall;
    logic                 busy;
    logic                 issue_valid;
    logic [1:0]           stage_idx;
    logic [GW-1:0]        group_idx;
    logic [NL*GW-1:0]     ma_idx;
    logic [NL*4-1:0]      bn_idx;
    logic [GW-1:0]        tw_base;
    logic                 ntt_done;

    r16_ntt_sched #(.LOG_N(LOG_N), .BU_LAT(BU_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stall       (stall),
        .busy        (busy),
        .issue_valid (issue_valid),
        .stage_idx   (stage_idx),
        .group_idx   (group_idx),
        .ma_idx      (ma_idx),
        .bn_idx      (bn_idx),
        .tw_base     (tw_base),
        .ntt_done    (ntt_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Timeline model: issue number, drain wait, and expected outputs after each edge.
    bit m_active;
    int m_next;
    int m_wait;
    int hold_cnt;
    bit exp_valid, exp_done, exp_busy;
    int exp_n;
    int cov [0:S-1][0:NIDX-1];

    function automatic int model_idx(int s, int g, int j);
        int t;
        t = 1 << (4 * s);
        return (g / t) * 16 * t + (g % t) + j * t;
    endfunction

    function automatic int dsum(int v);
        return ((v % 16) + ((v / 16) % 16) + ((v / 256) % 16) + ((v / 4096) % 16)) % 16;
    endfunction

    function automatic int model_tw(int s, int g);
        int t;
        t = 1 << (4 * s);
        return (g % t) << (LOG_N - 4 - 4 * s);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge();
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            m_next   = 0;
            m_wait   = 0;
            exp_busy = 1'b0;
        end else if (!m_active) begin
            exp_busy = start;
            if (start) begin
                m_active = 1'b1;
                m_next   = 0;
                m_wait   = 0;
            end
        end else begin
            exp_busy = 1'b1;
            if (m_wait > 0) begin
                m_wait--;
            end else if (m_next < S * G) begin
                if (stall) begin
                    hold_cnt++;
                end else begin
                    exp_valid = 1'b1;
                    exp_n     = m_next;
                    m_next++;
                    if (m_next % G == 0) m_wait = BU_LAT + 1;
                end
            end else begin
                exp_done = 1'b1;
                m_active = 1'b0;
            end
        end
    endtask

    task automatic compare();
        int s, g, m, b, e, mask, idx;
        chk("issue_valid", int'(issue_valid), int'(exp_valid));
        chk("ntt_done", int'(ntt_done), int'(exp_done));
        chk("busy", int'(busy), int'(exp_busy));
        if (exp_valid && issue_valid) begin
            s = exp_n / G;
            g = exp_n % G;
            chk("stage_idx", int'(stage_idx), s);
            chk("group_idx", int'(group_idx), g);
            chk("tw_base", int'(tw_base), model_tw(s, g));
            mask = 0;
            for (int j = 0; j < NL; j++) begin
                m = int'(ma_idx[j*GW +: GW]);
                b = int'(bn_idx[j*4 +: 4]);
                e = model_idx(s, g, j);
                chk("ma_lane", m, e / 16);
                chk("bn_lane", b, dsum(e));
                mask = mask | (1 << b);
                idx = m * 16 + (((b - dsum(m)) % 16) + 16) % 16;
                cov[s][idx]++;
                if (s == 0 && g == 3) begin
                    chk("spot_s0g3_bn", b, (3 + j) % 16);
                    chk("spot_s0g3_ma", m, 3);
                end
                if (s == 1 && g == 17) begin
                    chk("spot_s1g17_bn", b, (2 + j) % 16);
                    chk("spot_s1g17_ma", m, 16 + j);
                end
                if (s == 2 && g == 5) chk("spot_s2g5_idx", idx, 5 + 256 * j);
            end
            chk("bank_distinct", mask, 65535);
            if (s == 2 && g == 5) chk("spot_s2g5_tw", int'(tw_base), 5);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_valid"}, int'(issue_valid), 0);
        chk({tag, "_done"}, int'(ntt_done), 0);
        chk({tag, "_stage"}, int'(stage_idx), 0);
        chk({tag, "_group"}, int'(group_idx), 0);
        chk({tag, "_tw"}, int'(tw_base), 0);
        chk({tag, "_ma_any"}, int'(|ma_idx), 0);
        chk({tag, "_bn_any"}, int'(|bn_idx), 0);
    endtask

    // mode 0: no stall, 1: directed stalls, 2: random stalls.
    task automatic run(input int mode, input bit stray, input int abort_at, input int exp_len);
        int  len, vcount, gap, st3, bad;
        bit  seen_valid, done_seen;
        hold_cnt = 0;
        len = 1; vcount = 0; gap = 0; st3 = 0;
        seen_valid = 1'b0; done_seen = 1'b0;
        for (int s = 0; s < S; s++)
            for (int i = 0; i < NIDX; i++) cov[s][i] = 0;
        start = 1'b1;
        stall = (mode == 2);
        step();
        start = 1'b0;
        stall = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (abort_at > 0 && m_next >= abort_at) begin
                #3;
                rst = 1'b1;
                #1;
                check_zero("abort");
                step();
                step();
                rst = 1'b0;
                return;
            end
            case (mode)
                1: begin
                    stall = 1'b0;
                    if (m_wait == 0 && m_next == 100 && st3 < 3) begin
                        stall = 1'b1;
                        st3++;
                    end
                    if (m_wait > 0 && m_next == G) stall = 1'b1;
                end
                2: stall = ($urandom_range(0, 3) == 0);
                default: stall = 1'b0;
            endcase
            start = stray && ($urandom_range(0, 19) == 0);
            step();
            len++;
            if (issue_valid) begin
                vcount++;
                if (mode == 0 && seen_valid && gap > 0) chk("gap_len", gap, 9);
                gap = 0;
                seen_valid = 1'b1;
            end else if (seen_valid) begin
                gap++;
            end
            if (ntt_done) begin
                done_seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        stall = 1'b0;
        chk("done_seen", int'(done_seen), 1);
        chk("run_len", len, exp_len + ((mode == 2) ? hold_cnt : 0));
        chk("issue_count", vcount, 768);
        bad = 0;
        for (int s = 0; s < S; s++)
            for (int i = 0; i < NIDX; i++)
                if (cov[s][i] != 1) bad++;
        chk("coverage_bad", bad, 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        m_active = 1'b0; m_next = 0; m_wait = 0; hold_cnt = 0;
        exp_valid = 1'b0; exp_done = 1'b0; exp_busy = 1'b0; exp_n = 0;
        #2;
        check_zero("reset");
        chk("pin_s0g3_idx", model_idx(0, 3, 5), 53);
        chk("pin_s0g3_bn", dsum(model_idx(0, 3, 15)), 2);
        chk("pin_s1g17_idx", model_idx(1, 17, 2), 289);
        chk("pin_s1g17_bn", dsum(model_idx(1, 17, 2)), 4);
        chk("pin_s2g5_idx", model_idx(2, 5, 3), 773);
        chk("pin_s2g5_tw", model_tw(2, 5), 5);
        chk("pin_s1g17_tw", model_tw(1, 17), 16);
        step();
        step();
        rst = 1'b0;
        step();

        run(0, 1'b1, 0, 797);
        step();
        run(1, 1'b1, 0, 800);
        step();
        run(2, 1'b1, G + 50, 797);
        step();
        run(2, 1'b1, 0, 797);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
